// File: rtl/tone_sequencer.sv
// Step sequencer feeding the tone generator from a 16x8 melody memory.
// Start to first note: 2 cycles; each step costs 1 FETCH cycle + 4*(dur+1)*TICK_DIV PLAY cycles.
module tone_sequencer #(
    parameter int TICK_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [3:0] last_idx,
    output logic [3:0] note,
    output logic [1:0] octave,
    output logic       gate,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_mem [0:15];
    logic [7:0]      r_word;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_tick;
    logic [3:0]      r_step;
    logic [3:0]      r_last;
    logic            r_done;
    logic            w_tick_end;
    logic            w_last_tick;
    logic            w_step_end;
    logic            w_is_last;

    assign w_tick_end  = (r_presc == PW'(TICK_DIV - 1));
    // Final tick of the step is 4*dur+3, which is also the articulation gap.
    assign w_last_tick = (r_tick == {r_word[1:0], 2'b11});
    assign w_step_end  = (r_state == S_PLAY) && w_tick_end && w_last_tick;
    assign w_is_last   = (r_step == r_last);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_FETCH;
                S_FETCH: w_next = S_PLAY;
                S_PLAY:  if (w_step_end) w_next = (!w_is_last || loop) ? S_FETCH : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        note     = r_word[7:4];
        octave   = r_word[3:2];
        gate     = (r_state == S_PLAY) && (r_word[7:4] < 4'd12) && !w_last_tick;
        busy     = (r_state != S_IDLE);
        step_idx = r_step;
        done     = r_done;
    end

    // Melody memory is not reset; a read in FETCH sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_presc <= '0;
            r_tick  <= '0;
            r_step  <= '0;
            r_last  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_step_end && w_is_last && !loop && !stop;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_last <= last_idx;
                        r_step <= '0;
                    end
                end
                S_FETCH: begin
                    r_word  <= r_mem[r_step];
                    r_presc <= '0;
                    r_tick  <= '0;
                end
                S_PLAY: begin
                    if (w_tick_end) begin
                        r_presc <= '0;
                        r_tick  <= r_tick + 4'd1;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                    if (w_step_end && !stop) begin
                        if (!w_is_last)  r_step <= r_step + 4'd1;
                        else if (loop)   r_step <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
